// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared encodings for the instruction-fetch stage: FSM states,
//               next-PC select codes and the NOP instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  // Fetch FSM states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HAVE  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_t;

  // Next-PC select codes; any PCSrc with bit 1 set selects the jalr target
  localparam logic [1:0] c_PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] c_PCSRC_TARGET = 2'b01;
  localparam logic [1:0] c_PCSRC_JALR   = 2'b1?;

  // addi x0, x0, 0
  localparam logic [31:0] c_NOP = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_next_pc_sel.sv
// ============================================================================
// Module      : next_pc_sel
// Description : Combinational next-PC mux (PC+4 / PC+imm / jalr target) and
//               misaligned-target detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_sel
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic [1:0]      i_pcsrc,
  input  logic [XLEN-1:0] i_imm_ext,
  input  logic [XLEN-1:0] i_alu_result,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_jalr;

  // Adds wrap modulo 2^XLEN; jalr target drops bit 0
  assign w_target = i_pc + i_imm_ext;
  assign w_jalr   = {i_alu_result[XLEN-1:1], 1'b0};

  // Select the next PC from the controller's PCSrc
  always_comb begin
    o_next_pc = i_pc_plus4;
    casez (i_pcsrc)
      c_PCSRC_PLUS4:  o_next_pc = i_pc_plus4;
      c_PCSRC_TARGET: o_next_pc = w_target;
      c_PCSRC_JALR:   o_next_pc = w_jalr;
      default:        o_next_pc = i_pc_plus4;
    endcase
  end

  // Bit 1 set means the target is not word aligned
  assign o_misaligned = o_next_pc[1];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, fetches over a
//               valid/ready memory handshake, presents one instruction at a
//               time to decode, counts retired instructions and traps on
//               misaligned control-flow targets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     Instr,
  output logic            instr_valid,
  input  logic            instr_ack,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            fetch_fault,
  output logic [31:0]     retired
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [31:0]     r_retired;
  logic            r_req_valid;
  logic            r_instr_valid;
  logic            r_fault;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;

  assign w_pc_plus4 = r_pc + XLEN'(4);

  next_pc_sel #(
    .XLEN (XLEN)
  ) u_next_pc_sel (
    .i_pc         (r_pc),
    .i_pc_plus4   (w_pc_plus4),
    .i_pcsrc      (PCSrc),
    .i_imm_ext    (ImmExt),
    .i_alu_result (ALUResult),
    .o_next_pc    (w_next_pc),
    .o_misaligned (w_misaligned)
  );

  // Fetch FSM with PC, instruction latch, retire counter and registered valids
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= c_NOP;
      r_retired     <= '0;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_REQ;
          r_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_instr       <= imem_rsp_data;
            r_state       <= S_HAVE;
            r_instr_valid <= 1'b1;
          end
        end
        S_HAVE: begin
          if (instr_ack) begin
            r_retired     <= r_retired + 32'd1;
            r_instr_valid <= 1'b0;
            if (w_misaligned) begin
              // PC keeps the faulting instruction's address for diagnosis
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_pc        <= w_next_pc;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          r_state       <= S_FAULT;
          r_req_valid   <= 1'b0;
          r_instr_valid <= 1'b0;
          r_fault       <= 1'b1;
        end
        default: begin
          r_state       <= S_IDLE;
          r_req_valid   <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign Instr          = r_instr;
  assign instr_valid    = r_instr_valid;
  assign PC             = r_pc;
  assign PCPlus4        = w_pc_plus4;
  assign fetch_fault    = r_fault;
  assign retired        = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        instr_ack;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_fault;
  logic [31:0] retired;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .Instr          (Instr),
    .instr_valid    (instr_valid),
    .instr_ack      (instr_ack),
    .PCSrc          (PCSrc),
    .ImmExt         (ImmExt),
    .ALUResult      (ALUResult),
    .PC             (PC),
    .PCPlus4        (PCPlus4),
    .fetch_fault    (fetch_fault),
    .retired        (retired)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // From REQ: accept the request, return the word on the following edge
  task automatic fetch(input logic [31:0] word);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
  endtask

  // From HAVE: commit the instruction with the given next-PC controls
  task automatic ack(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    instr_ack = 1'b1;
    PCSrc     = src;
    ImmExt    = imm;
    ALUResult = alu;
    tick();
    instr_ack = 1'b0;
    PCSrc     = 2'b00;
    ImmExt    = 32'h0;
    ALUResult = 32'h0;
  endtask

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ack      = 1'b0;
    PCSrc          = 2'b00;
    ImmExt         = 32'h0;
    ALUResult      = 32'h0;

    // ---- Reset state
    tick(2);
    chk32("rst_pc", PC, 32'h0);
    chk32("rst_instr", Instr, 32'h0000_0013);
    chk32("rst_retired", retired, 32'h0);
    chk1("rst_fault", fetch_fault, 1'b0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_instr_valid", instr_valid, 1'b0);

    // ---- Basic fetch / sequential ack
    reset = 1'b1;
    tick();
    chk1("t1_req_valid", imem_req_valid, 1'b1);
    chk32("t1_addr", imem_addr, 32'h0);
    fetch(32'h0050_0093);
    chk1("t1_instr_valid", instr_valid, 1'b1);
    chk32("t1_instr", Instr, 32'h0050_0093);
    chk32("t1_pc", PC, 32'h0);
    chk32("t1_pcplus4", PCPlus4, 32'h4);
    ack(2'b00, 32'h0, 32'h0);
    chk1("t1_next_req", imem_req_valid, 1'b1);
    chk32("t1_next_addr", imem_addr, 32'h4);
    chk32("t1_retired", retired, 32'h1);
    chk1("t1_instr_valid_drop", instr_valid, 1'b0);

    // ---- Ack outside HAVE is ignored
    instr_ack = 1'b1;
    PCSrc     = 2'b01;
    ImmExt    = 32'h40;
    tick();
    instr_ack = 1'b0;
    PCSrc     = 2'b00;
    ImmExt    = 32'h0;
    chk32("stray_ack_pc", PC, 32'h4);
    chk32("stray_ack_retired", retired, 32'h1);

    // ---- Branch: 4 + 0xC = 0x10, then 0x10 - 8 = 0x08
    fetch(32'h0000_0063);
    ack(2'b01, 32'h0000_000C, 32'h0);
    chk32("t2_addr_10", imem_addr, 32'h10);
    fetch(32'hFE00_0CE3);
    ack(2'b01, 32'hFFFF_FFF8, 32'h0);
    chk32("t2_addr_08", imem_addr, 32'h08);
    chk32("t2_retired", retired, 32'h3);

    // ---- Backpressure on request, then stalled ack
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("t4_bp_valid", imem_req_valid, 1'b1);
      chk32("t4_bp_addr", imem_addr, 32'h08);
    end
    fetch(32'h00A0_0113);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("t4_stall_valid", instr_valid, 1'b1);
      chk32("t4_stall_instr", Instr, 32'h00A0_0113);
      chk32("t4_stall_pc", PC, 32'h08);
      chk32("t4_stall_retired", retired, 32'h3);
    end
    ack(2'b00, 32'h0, 32'h0);
    chk32("t4_addr", imem_addr, 32'h0C);
    chk32("t4_retired", retired, 32'h4);

    // ---- Wrap: jump to 0xFFFF_FFFC, then +4 wraps to 0
    fetch(32'h0000_0067);
    ack(2'b10, 32'h0, 32'hFFFF_FFFC);
    chk32("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0013);
    chk32("t6_pcplus4_wrap", PCPlus4, 32'h0);
    ack(2'b00, 32'h0, 32'h0);
    chk32("t6_addr_wrap", imem_addr, 32'h0);
    chk32("t6_retired", retired, 32'h6);

    // ---- Retired counter wrap from all-ones
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    #1;
    chk32("t6_retired_preload", retired, 32'hFFFF_FFFF);
    fetch(32'h0000_0013);
    ack(2'b00, 32'h0, 32'h0);
    chk32("t6_retired_wrap", retired, 32'h0);
    chk32("t6_addr_after", imem_addr, 32'h4);

    // ---- jalr to 0x103 -> 0x102 misaligned -> FAULT
    fetch(32'h0000_0067);
    ack(2'b10, 32'h0, 32'h0000_0103);
    chk1("t3_fault", fetch_fault, 1'b1);
    chk1("t3_req_valid", imem_req_valid, 1'b0);
    chk1("t3_instr_valid", instr_valid, 1'b0);
    chk32("t3_pc_held", PC, 32'h4);
    chk32("t3_retired", retired, 32'h1);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    instr_ack      = 1'b1;
    tick(3);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ack      = 1'b0;
    chk1("t3_fault_sticky", fetch_fault, 1'b1);
    chk1("t3_no_req", imem_req_valid, 1'b0);
    chk32("t3_pc_stuck", PC, 32'h4);
    chk32("t3_instr_stuck", Instr, 32'h0000_0067);

    // ---- Reset out of FAULT
    reset = 1'b0;
    tick();
    chk1("t5_fault_cleared", fetch_fault, 1'b0);
    chk32("t5_pc_reset", PC, 32'h0);
    reset = 1'b1;
    tick();
    chk1("t5_req_after_fault", imem_req_valid, 1'b1);

    // ---- Reset while in WAIT, late response ignored
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk1("t5_in_wait", imem_req_valid, 1'b0);
    reset = 1'b0;
    tick();
    reset          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    chk32("t5_instr_nop", Instr, 32'h0000_0013);
    chk32("t5_pc", PC, 32'h0);
    chk32("t5_retired", retired, 32'h0);
    chk1("t5_req_again", imem_req_valid, 1'b1);
    tick();
    chk1("t5_no_instr_valid", instr_valid, 1'b0);

    // ---- jalr to 0x101 -> 0x100, aligned
    fetch(32'h0000_8067);
    chk32("t3b_instr", Instr, 32'h0000_8067);
    ack(2'b11, 32'h0, 32'h0000_0101);
    chk32("t3b_addr", imem_addr, 32'h100);
    chk1("t3b_no_fault", fetch_fault, 1'b0);
    chk1("t3b_req", imem_req_valid, 1'b1);
    chk32("t3b_retired", retired, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the decode/control path.
- Owns the PC register and issues requests to instruction memory over a valid/ready handshake.
- Presents one instruction at a time to the core and computes the next PC from the 2-bit PCSrc the controller produces.
- Also counts retired instructions and flags misaligned control-flow targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- XLEN, 32, address and data width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset asserted.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  XLEN  fetch address; always equals PC.
- imem_rsp_valid  input  1  read data valid.
- imem_rsp_data  input  32  fetched instruction word.
- Instr  output  32  instruction presented to decode.
- instr_valid  output  1  Instr, PC and PCPlus4 are valid.
- instr_ack  input  1  core commits the presented instruction this cycle.
- PCSrc  input  2  next-PC select, sampled only when instr_ack is high.
- ImmExt  input  XLEN  branch/jal offset.
- ALUResult  input  XLEN  jalr target.
- PC  output  XLEN  current PC.
- PCPlus4  output  XLEN  PC + 4.
- fetch_fault  output  1  misaligned target detected; sticky.
- retired  output  32  count of acknowledged instructions.

Behaviour:
- Reset (reset=0 at a clock edge):
  - PC=RESET_PC, Instr=32'h0000_0013 (NOP), retired=0, fetch_fault=0, state=IDLE.
  - All handshake outputs are 0.
  - Reset takes priority over every other event, including an outstanding request; a late imem_rsp_valid arriving in IDLE is ignored.
- State machine: IDLE, REQ, WAIT, HAVE, FAULT.
- IDLE: go to REQ on the next cycle.
- REQ:
  - imem_req_valid=1 and imem_addr=PC, held stable until imem_req_ready.
  - On ready go to WAIT.
- WAIT:
  - On imem_rsp_valid, latch imem_rsp_data into Instr and go to HAVE.
  - Memory returns data no earlier than the cycle after acceptance. rsp_valid in any state other than WAIT is ignored.
- HAVE:
  - instr_valid=1; Instr, PC and PCPlus4 are held stable until instr_ack.
  - On instr_ack: retired increments (wraps 2^32-1 -> 0) and next PC is selected:
    - PCSrc 00 -> PC+4
    - PCSrc 01 -> PC+ImmExt
    - PCSrc 10 or 11 -> ALUResult with bit 0 cleared
  - All additions are modulo 2^XLEN (wrap-around, no overflow flag).
  - If the next PC has bit 1 set: go to FAULT; PC keeps the old value and fetch_fault=1.
  - Otherwise PC updates and state goes to REQ.
  - Latency: ack at cycle t -> imem_req_valid=1 with the new address at t+1.
  - Best case from request acceptance to instr_valid is 2 cycles.
- instr_ack outside HAVE is ignored; PCSrc, ImmExt and ALUResult are don't-care then.
- FAULT:
  - All valids are 0 and fetch_fault=1.
  - Leaves only through reset.
- PCPlus4 is combinational from PC; all other outputs are registered or decoded from state.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE=0, REQ=1, WAIT=2, HAVE=3, FAULT=4);
  - PCSrc encodings (PCSRC_PLUS4=2'b00, PCSRC_TARGET=2'b01, PCSRC_JALR=2'b1x);
  - the NOP constant 32'h0000_0013.
- One sub-module, next_pc_sel: combinational mux and adders producing the next PC and the misalign flag.
- The FSM, PC register, Instr latch and retired counter remain in fetch_unit.

Test Plan:
1. Reset then hold imem_req_ready=1, rsp 1 cycle later with 32'h00500093 -> imem_addr=0 at the first REQ; instr_valid with Instr=32'h00500093, PC=0, PCPlus4=4; ack with PCSrc=00 -> next request addr=4, retired=1.
2. Branch: PC=0x10, ack with PCSrc=01, ImmExt=32'hFFFF_FFF8 -> next imem_addr=0x08.
3. jalr: ack with PCSrc=10, ALUResult=0x0000_0103 -> next imem_addr=0x102 is misaligned -> FAULT, fetch_fault=1, PC stays old, no further requests; then with ALUResult=0x101 -> addr 0x100, normal.
4. Backpressure: imem_req_ready=0 for 5 cycles -> imem_req_valid=1 with imem_addr constant throughout. Stall ack for 3 cycles in HAVE -> Instr/PC unchanged, retired unchanged.
5. Reset asserted while in WAIT, rsp_valid arrives the following cycle -> response ignored, PC=RESET_PC, Instr=NOP, retired=0, new REQ two cycles after reset release.
6. Wrap: PC=0xFFFF_FFFC, ack with PCSrc=00 -> next PC=0x0000_0000. Preload retired=32'hFFFF_FFFF, one ack -> retired=0.
